// File: rtl/alu_exec_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_exec_unit: operand select, B-shifter, ALU with multi-cycle shift-add    |
// | MUL, registered C/{V,N,Z} status and a start/busy/done handshake.           |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module alu_exec_unit #(
  parameter int WIDTH     = 16,
  parameter int IMM_WIDTH = 5,
  parameter int SEXT_IMM  = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] datapath_in,
  input  logic             asel,
  input  logic             bsel,
  input  logic [1:0]       shift,
  input  logic [2:0]       ALUop,
  input  logic             loadc,
  input  logic             loads,
  output logic [WIDTH-1:0] C,
  output logic [2:0]       status,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0] c_OP_SUB = 3'b001;
  localparam logic [2:0] c_OP_AND = 3'b010;
  localparam logic [2:0] c_OP_NOT = 3'b011;
  localparam logic [2:0] c_OP_OR  = 3'b100;
  localparam logic [2:0] c_OP_XOR = 3'b101;
  localparam logic [2:0] c_OP_MUL = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_ain;
  logic [WIDTH-1:0]     r_bin;
  logic [2:0]           r_op;
  logic                 r_loadc;
  logic                 r_loads;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;

  logic [WIDTH-1:0]     w_imm;
  logic [WIDTH-1:0]     w_bshift;
  logic [WIDTH-1:0]     w_ain;
  logic [WIDTH-1:0]     w_bin;
  logic [WIDTH-1:0]     w_sum;
  logic [WIDTH-1:0]     w_diff;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic [WIDTH-1:0]     w_res;
  logic                 w_v;
  logic [2:0]           w_flags;
  logic                 w_accept;

  generate
    if (IMM_WIDTH < WIDTH) begin : g_imm_ext
      logic w_imm_fill;
      logic w_unused_imm_msbs;
      assign w_imm_fill        = (SEXT_IMM != 0) ? datapath_in[IMM_WIDTH-1] : 1'b0;
      assign w_imm             = {{(WIDTH-IMM_WIDTH){w_imm_fill}}, datapath_in[IMM_WIDTH-1:0]};
      assign w_unused_imm_msbs = ^datapath_in[WIDTH-1:IMM_WIDTH];
    end else begin : g_imm_full
      assign w_imm = datapath_in;
    end
  endgenerate

  always_comb begin
    w_bshift = B;
    case (shift)
      2'b01:   w_bshift = {B[WIDTH-2:0], 1'b0};
      2'b10:   w_bshift = {1'b0, B[WIDTH-1:1]};
      2'b11:   w_bshift = {B[WIDTH-1], B[WIDTH-1:1]};
      default: w_bshift = B;
    endcase
  end

  assign w_ain    = asel ? A : '0;
  assign w_bin    = bsel ? w_imm : w_bshift;
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  assign w_sum      = r_ain + r_bin;
  assign w_diff     = r_ain + ~r_bin + WIDTH'(1);
  // Multiplier bits are consumed from r_bin LSB first while the multiplicand shifts left.
  assign w_acc_next = r_acc + (r_bin[0] ? r_mcand : '0);

  always_comb begin
    w_res = w_sum;
    w_v   = (r_ain[WIDTH-1] == r_bin[WIDTH-1]) && (w_sum[WIDTH-1] != r_ain[WIDTH-1]);
    case (r_op)
      c_OP_SUB: begin
        w_res = w_diff;
        w_v   = (r_ain[WIDTH-1] != r_bin[WIDTH-1]) && (w_diff[WIDTH-1] != r_ain[WIDTH-1]);
      end
      c_OP_AND: begin w_res = r_ain & r_bin; w_v = 1'b0; end
      c_OP_NOT: begin w_res = ~r_bin;        w_v = 1'b0; end
      c_OP_OR:  begin w_res = r_ain | r_bin; w_v = 1'b0; end
      c_OP_XOR: begin w_res = r_ain ^ r_bin; w_v = 1'b0; end
      c_OP_MUL: begin
        w_res = w_acc_next[WIDTH-1:0];
        w_v   = |w_acc_next[2*WIDTH-1:WIDTH];
      end
      default: ;
    endcase
  end

  assign w_flags = {w_v, w_res[WIDTH-1], (w_res == '0)};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_ain   <= '0;
      r_bin   <= '0;
      r_op    <= '0;
      r_loadc <= 1'b0;
      r_loads <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_mcand <= '0;
      C       <= '0;
      status  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (w_accept) begin
            r_ain   <= w_ain;
            r_bin   <= w_bin;
            r_op    <= ALUop;
            r_loadc <= loadc;
            r_loads <= loads;
            r_cnt   <= CW'(WIDTH-1);
            r_acc   <= '0;
            r_mcand <= {{WIDTH{1'b0}}, w_ain};
            busy    <= 1'b1;
            r_state <= (ALUop == c_OP_MUL) ? S_MUL : S_EXEC;
          end else begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_EXEC: begin
          if (r_loadc) C      <= w_res;
          if (r_loads) status <= w_flags;
          busy    <= 1'b0;
          done    <= 1'b1;
          r_state <= S_DONE;
        end
        S_MUL: begin
          r_acc   <= w_acc_next;
          r_mcand <= r_mcand << 1;
          r_bin   <= r_bin >> 1;
          r_cnt   <= r_cnt - CW'(1);
          if (r_cnt == '0) begin
            if (r_loadc) C      <= w_res;
            if (r_loads) status <= w_flags;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Parametrised execution unit for the RISC datapath: operand select, B-shifter, ALU, and registered C/status outputs. It extends the single-cycle 16-bit compute stage with configurable width, configurable immediate width and extension, OR/XOR/MUL operations, and three status flags (Z, N, V). It adds a start/busy/done handshake so the controller FSM can issue multi-cycle multiplies. It sits between the register-file read ports (A, B) and the writeback mux (C).

Parameters:
WIDTH, 16, datapath width in bits (>=4)
IMM_WIDTH, 5, width of immediate field taken from datapath_in[IMM_WIDTH-1:0]
SEXT_IMM, 0, 1 = sign-extend immediate, 0 = zero-extend

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
start  in  1  issue operation; accepted only when busy=0
A  in  WIDTH  register A operand
B  in  WIDTH  register B operand
datapath_in  in  WIDTH  immediate source
asel  in  1  1: Ain=A, 0: Ain=0
bsel  in  1  1: Bin=extended immediate, 0: Bin=shifted B
shift  in  2  00 pass, 01 LSL1, 10 LSR1, 11 ASR1 (applied to B)
ALUop  in  3  000 ADD, 001 SUB, 010 AND, 011 NOT Bin, 100 OR, 101 XOR, 110 MUL, 111 reserved (behaves as ADD)
loadc  in  1  write C at completion
loads  in  1  write status at completion
C  out  WIDTH  registered result
status  out  3  registered flags {V,N,Z}
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (reset_n=0, async): C=0, status=3'b000, busy=0, done=0, FSM=IDLE, internal operand/accumulator regs cleared. Reset mid-MUL aborts the operation; no C/status write.
- Operand capture: on a clock edge with start=1 and busy=0, register Ain, Bin (post-select/shift), ALUop, loadc, loads. Later input changes do not affect the in-flight op.
- start while busy=1: ignored, no queuing.
- FSM states: IDLE, EXEC, MUL, DONE.
  - IDLE: start -> EXEC (non-MUL) or MUL (counter=WIDTH-1, acc=0).
  - EXEC: compute, write C/status per latched loadc/loads -> DONE. busy=1.
  - MUL: shift-add, 1 multiplier bit per cycle, LSB first; counter decrements; at counter=0 write C/status -> DONE. busy=1 for WIDTH cycles.
  - DONE: done=1 for exactly one cycle, busy=0; start is accepted here (back-to-back) -> EXEC/MUL, else IDLE.
- Latency: non-MUL, start edge to done high = 2 cycles. MUL: WIDTH+1 cycles. C/status update on the edge entering DONE.
- Arithmetic: all results are WIDTH bits; wrap-around modulo 2^WIDTH. SUB = Ain + ~Bin + 1. MUL is unsigned; C = low WIDTH bits of the product.
- Flags, computed from the WIDTH-bit result:
  - Z = (result==0).
  - N = result[WIDTH-1].
  - V: ADD is signed overflow (operand signs equal, result sign differs). SUB is operand signs differ and result sign differs from Ain. MUL sets V if the upper WIDTH product bits are nonzero. V=0 for logic ops.
- loadc=0 / loads=0: the respective register holds its value; done still pulses.
- Immediate: bits [IMM_WIDTH-1:0] of datapath_in, extended to WIDTH per SEXT_IMM. The shifter is bypassed when bsel=1.
- Shifter: LSL1 fills 0 at bit 0. LSR1 fills 0 at the MSB. ASR1 replicates B[WIDTH-1].

Test Plan:
- Reset mid-MUL: start MUL with A=3, B=5, deassert reset_n at cycle 4 -> C=0, status=000, busy=0 immediately; no done pulse.
- ADD overflow: asel=1, bsel=0, shift=00, A=16'h7FFF, B=16'h0001, ADD, loadc=loads=1 -> 2 cycles later done=1, C=16'h8000, status=3'b110 (V=1, N=1).
- SUB zero with ASR: A=16'hFFFF, B=16'hFFFE, shift=11 (Bin=16'hFFFF), SUB -> C=0, status=3'b001.
- Immediate path: bsel=1, asel=0, datapath_in=16'h001F, ADD. With SEXT_IMM=0 -> C=16'h001F. With SEXT_IMM=1 -> C=16'hFFFF, N=1.
- MUL: A=16'h0100, B=16'h0100, MUL -> busy high 16 cycles, done at cycle 17, C=16'h0000, status=3'b101 (V=1, Z=1). Then A=12, B=11 -> C=132, status=000.
- Handshake: start held during busy is ignored. start in the DONE cycle begins the next op with no idle cycle. loadc=0 leaves C unchanged while status updates.
